// File: rtl/lsu.sv
// lsu: load/store unit between the memory stage and dcache.
// Issues one cache access at a time, holds the request until c_ready,
// formats load data by RV64I width/sign, and aborts stuck accesses
// with a watchdog.
module lsu #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [15:0] addr,
    input  logic [63:0] store_data,
    output logic        stall,
    output logic        result_valid,
    output logic [63:0] load_result,
    output logic        err,
    output logic [15:0] c_address,
    output logic [63:0] c_data,
    output logic        c_rd,
    output logic [7:0]  c_wr,
    input  logic        c_ready,
    input  logic [63:0] c_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wdog;
    logic [2:0]  f3_q;
    logic        load_q;
    logic        illegal;
    logic        timeout_hit;
    logic [7:0]  wr_mask;
    logic [63:0] fmt_data;

    assign timeout_hit = (wdog == 8'(TIMEOUT - 1));

    // Decode illegal operations and the store byte-enable mask from live inputs
    always_comb begin
        illegal = (req_load == req_store)
                  || (req_load && (funct3 == 3'b111))
                  || (req_store && funct3[2]);
        wr_mask = '0;
        case (funct3[1:0])
            2'b00:   wr_mask = 8'b0000_0001;
            2'b01:   wr_mask = 8'b0000_0011;
            2'b10:   wr_mask = 8'b0000_1111;
            default: wr_mask = 8'b1111_1111;
        endcase
    end

    // Format returned cache data using the funct3 latched at issue
    always_comb begin
        fmt_data = c_rdata;
        case (f3_q)
            3'b000:  fmt_data = {{56{c_rdata[7]}},  c_rdata[7:0]};
            3'b001:  fmt_data = {{48{c_rdata[15]}}, c_rdata[15:0]};
            3'b010:  fmt_data = {{32{c_rdata[31]}}, c_rdata[31:0]};
            3'b100:  fmt_data = {{56{1'b0}}, c_rdata[7:0]};
            3'b101:  fmt_data = {{48{1'b0}}, c_rdata[15:0]};
            3'b110:  fmt_data = {{32{1'b0}}, c_rdata[31:0]};
            default: fmt_data = c_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = illegal ? RESP : REQ;
                end
            end
            REQ: begin
                if (c_ready || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pipeline stall: combinational so the request cycle itself is frozen
    always_comb begin
        stall = ((state == IDLE) && req_valid) || (state == REQ);
    end

    // Registered outputs: cache request, watchdog, result and error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_rd         <= 1'b0;
            c_wr         <= '0;
            c_address    <= '0;
            c_data       <= '0;
            load_result  <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            wdog         <= '0;
            f3_q         <= '0;
            load_q       <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            err          <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (illegal) begin
                            result_valid <= 1'b1;
                            err          <= 1'b1;
                            load_result  <= '0;
                        end else begin
                            c_address <= addr;
                            f3_q      <= funct3;
                            load_q    <= req_load;
                            wdog      <= '0;
                            if (req_load) begin
                                c_rd <= 1'b1;
                                c_wr <= '0;
                            end else begin
                                c_rd   <= 1'b0;
                                c_data <= store_data;
                                c_wr   <= wr_mask;
                            end
                        end
                    end
                end
                REQ: begin
                    if (c_ready) begin
                        load_result  <= load_q ? fmt_data : '0;
                        c_rd         <= 1'b0;
                        c_wr         <= '0;
                        wdog         <= '0;
                        result_valid <= 1'b1;
                    end else if (timeout_hit) begin
                        load_result  <= '0;
                        c_rd         <= 1'b0;
                        c_wr         <= '0;
                        wdog         <= '0;
                        result_valid <= 1'b1;
                        err          <= 1'b1;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with a scoreboard of expected results
// and a behavioural cache stub with per-access latency.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_load;
    logic        req_store;
    logic [2:0]  funct3;
    logic [15:0] addr;
    logic [63:0] store_data;
    logic        stall;
    logic        result_valid;
    logic [63:0] load_result;
    logic        err;
    logic [15:0] c_address;
    logic [63:0] c_data;
    logic        c_rd;
    logic [7:0]  c_wr;
    logic        c_ready;
    logic [63:0] c_rdata;

    int checks;
    int failures;

    typedef struct {
        logic [63:0] lr;
        logic        er;
    } sb_t;

    sb_t sb[$];
    logic [63:0] mem [logic [15:0]];

    lsu #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_load     (req_load),
        .req_store    (req_store),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .stall        (stall),
        .result_valid (result_valid),
        .load_result  (load_result),
        .err          (err),
        .c_address    (c_address),
        .c_data       (c_data),
        .c_rd         (c_rd),
        .c_wr         (c_wr),
        .c_ready      (c_ready),
        .c_rdata      (c_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access: cycle 0 is the cycle req_valid is sampled. lat is the cycle
    // c_ready is driven (-1 = never), rv the cycle result_valid must appear.
    task automatic do_op(input string name, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [15:0] a,
                         input logic [63:0] sd, input int lat, input int rv,
                         input logic [63:0] exp_lr);
        logic       legal;
        logic       exp_err;
        logic [7:0] mask;
        logic       in_win;
        sb_t        e;
        sb_t        got;
        legal   = (rv != 1);
        exp_err = !legal || (lat < 0);
        mask    = '0;
        if (legal && st) begin
            case (f3[1:0])
                2'b00:   mask = 8'h01;
                2'b01:   mask = 8'h03;
                2'b10:   mask = 8'h0F;
                default: mask = 8'hFF;
            endcase
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_load   = ld;
        req_store  = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        c_ready    = 1'b0;
        c_rdata    = {$urandom(), $urandom()};
        e.lr = exp_lr;
        e.er = exp_err;
        sb.push_back(e);
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) mem[a][8*i +: 8] = sd[8*i +: 8];
        end
        #1;
        chk($sformatf("%s_c0_stall", name), stall, 1'b1);
        chk($sformatf("%s_c0_rd", name), c_rd, 1'b0);
        chk($sformatf("%s_c0_rv", name), result_valid, 1'b0);
        for (int c = 1; c <= rv; c++) begin
            @(posedge clk);
            #1;
            c_ready = (c == lat);
            c_rdata = (c == lat) ? mem[a] : {$urandom(), $urandom()};
            #1;
            in_win = legal && (c <= rv - 1);
            chk($sformatf("%s_c%0d_stall", name, c), stall, (c < rv));
            chk($sformatf("%s_c%0d_rd", name, c), c_rd, in_win && ld);
            chk($sformatf("%s_c%0d_wr", name, c), c_wr, in_win ? mask : 8'h00);
            chk($sformatf("%s_c%0d_rv", name, c), result_valid, (c == rv));
            if (in_win) begin
                chk($sformatf("%s_c%0d_addr", name, c), c_address, a);
                if (st) chk($sformatf("%s_c%0d_data", name, c), c_data, sd);
            end
            if (result_valid === 1'b1) begin
                chk($sformatf("%s_sb_nonempty", name), sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    chk($sformatf("%s_result", name), load_result, got.lr);
                    chk($sformatf("%s_err", name), err, got.er);
                end
            end else begin
                chk($sformatf("%s_c%0d_err", name, c), err, 1'b0);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        c_ready   = 1'b0;
        #1;
        chk($sformatf("%s_after_rv", name), result_valid, 1'b0);
        chk($sformatf("%s_after_stall", name), stall, 1'b0);
        chk($sformatf("%s_after_rd", name), c_rd, 1'b0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_load   = 1'b0;
        req_store  = 1'b0;
        funct3     = '0;
        addr       = '0;
        store_data = '0;
        c_ready    = 1'b0;
        c_rdata    = '0;
        mem[16'h0104] = 64'h0;
        mem[16'h0200] = 64'hAAAA_AAAA_AAAA_AAAA;
        mem[16'h0300] = 64'h1111_1111_1111_1111;
        mem[16'h2208] = 64'h0000_0000_8000_0000;
        mem[16'h0400] = 64'h5555_5555_5555_5555;

        #1;
        chk("rst_c_rd", c_rd, 1'b0);
        chk("rst_c_wr", c_wr, 8'h00);
        chk("rst_c_address", c_address, 16'h0000);
        chk("rst_c_data", c_data, 64'h0);
        chk("rst_load_result", load_result, 64'h0);
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_stall", stall, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_op("sd",   1'b0, 1'b1, 3'b011, 16'h0104, 64'hFFFF_FFFF_FFFF_FF80, 2, 3, 64'h0);
        do_op("lb",   1'b1, 1'b0, 3'b000, 16'h0104, 64'h0, 2, 3, 64'hFFFF_FFFF_FFFF_FF80);
        do_op("lbu",  1'b1, 1'b0, 3'b100, 16'h0104, 64'h0, 2, 3, 64'h0000_0000_0000_0080);
        do_op("sw",   1'b0, 1'b1, 3'b010, 16'h0200, 64'h0000_0000_8000_0001, 2, 3, 64'h0);
        do_op("lwu",  1'b1, 1'b0, 3'b110, 16'h0200, 64'h0, 2, 3, 64'h0000_0000_8000_0001);
        do_op("lw",   1'b1, 1'b0, 3'b010, 16'h0200, 64'h0, 2, 3, 64'hFFFF_FFFF_8000_0001);
        do_op("sh",   1'b0, 1'b1, 3'b001, 16'h0300, 64'h1234_5678_9ABC_DEF0, 2, 3, 64'h0);
        do_op("lh",   1'b1, 1'b0, 3'b001, 16'h0300, 64'h0, 2, 3, 64'hFFFF_FFFF_FFFF_DEF0);
        do_op("lhu",  1'b1, 1'b0, 3'b101, 16'h0300, 64'h0, 2, 3, 64'h0000_0000_0000_DEF0);
        do_op("sb",   1'b0, 1'b1, 3'b000, 16'h0104, 64'hDEAD_BEEF_0000_007F, 2, 3, 64'h0);
        do_op("ld",   1'b1, 1'b0, 3'b011, 16'h0104, 64'h0, 2, 3, 64'hFFFF_FFFF_FFFF_FF7F);
        do_op("lb2",  1'b1, 1'b0, 3'b000, 16'h0104, 64'h0, 2, 3, 64'h0000_0000_0000_007F);
        do_op("miss", 1'b1, 1'b0, 3'b010, 16'h2208, 64'h0, 14, 15, 64'hFFFF_FFFF_8000_0000);

        do_op("ill_both",  1'b1, 1'b1, 3'b000, 16'h0104, 64'h0, -1, 1, 64'h0);
        do_op("ill_st100", 1'b0, 1'b1, 3'b100, 16'h0104, 64'h0, -1, 1, 64'h0);
        do_op("ill_ld111", 1'b1, 1'b0, 3'b111, 16'h0104, 64'h0, -1, 1, 64'h0);
        do_op("ill_none",  1'b0, 1'b0, 3'b011, 16'h0104, 64'h0, -1, 1, 64'h0);

        do_op("timeout", 1'b1, 1'b0, 3'b011, 16'h0400, 64'h0, -1, 17, 64'h0);

        // Reset in cycle 6 of a miss
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_load  = 1'b1;
        req_store = 1'b0;
        funct3    = 3'b010;
        addr      = 16'h2208;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 6) rst = 1'b1;
            #1;
            if (c < 6) begin
                chk($sformatf("rstmiss_c%0d_rd", c), c_rd, 1'b1);
            end else begin
                chk("rstmiss_rd_drop", c_rd, 1'b0);
                chk("rstmiss_wr_drop", c_wr, 8'h00);
                chk("rstmiss_stall_req", stall, 1'b1);
            end
            chk($sformatf("rstmiss_c%0d_rv", c), result_valid, 1'b0);
        end
        req_valid = 1'b0;
        #1;
        chk("rstmiss_stall_noreq", stall, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) rst = 1'b0;
            #1;
            chk($sformatf("rstmiss_hold%0d_rv", c), result_valid, 1'b0);
            chk($sformatf("rstmiss_hold%0d_rd", c), c_rd, 1'b0);
        end
        do_op("ld_after_rst", 1'b1, 1'b0, 3'b011, 16'h0104, 64'h0, 2, 3, 64'hFFFF_FFFF_FFFF_FF7F);

        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
